z_calculator_pipe: RTL and testbench

//   Pipelined, parametrised successor to the z_calculator Julia iterator. Each accepted token

---
 rtl/z_calculator_pipe.sv | 140 ++++++++++++++
 tb/tb_z_calculator_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/z_calculator_pipe.sv
// rtl/z_calculator_pipe.sv - three-stage pipelined Julia iteration z' = z^2 + c with valid/ready
// Fixed-point Q INTEGRAL.FRACTIONAL; every product and sum saturates to the signed WIDTH range.
module z_calculator_pipe #(
  parameter int WIDTH      = 20,
  parameter int FRACTIONAL = 10,
  parameter int INTEGRAL   = 10,
  parameter int ITER_WIDTH = 8,
  parameter int MAX_ITER   = 255,
  parameter int ESCAPE_SQ  = 4096,
  parameter int ID_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      z_real_in,
  input  logic [WIDTH-1:0]      z_imag_in,
  input  logic [WIDTH-1:0]      c_real_in,
  input  logic [WIDTH-1:0]      c_imag_in,
  input  logic [ITER_WIDTH-1:0] iteration_in,
  input  logic                  done_in,
  input  logic [ID_WIDTH-1:0]   id_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      z_real_out,
  output logic [WIDTH-1:0]      z_imag_out,
  output logic [WIDTH-1:0]      size_squared_out,
  output logic [ITER_WIDTH-1:0] iteration_out,
  output logic                  done_out,
  output logic [ID_WIDTH-1:0]   id_out
);

  localparam int PW  = 2 * WIDTH;
  localparam int MAG = INTEGRAL + FRACTIONAL - 1;
  localparam logic [WIDTH-1:0]      SMAX  = {1'b0, {MAG{1'b1}}};
  localparam logic [WIDTH-1:0]      SMIN  = ~SMAX;
  localparam logic [ITER_WIDTH-1:0] MAX_I = ITER_WIDTH'(MAX_ITER);
  localparam logic [WIDTH-1:0]      ESC   = WIDTH'(ESCAPE_SQ);

  function automatic logic [PW-1:0] f_sx(input logic [WIDTH-1:0] a);
    return {{(PW-WIDTH){a[WIDTH-1]}}, a};
  endfunction

  function automatic logic [WIDTH-1:0] f_sat(input logic [PW-1:0] v);
    if (v[PW-1:WIDTH-1] == '0 || v[PW-1:WIDTH-1] == '1) return v[WIDTH-1:0];
    else if (v[PW-1]) return SMIN;
    else return SMAX;
  endfunction

  // dbl folds the factor of two into the shift so 2*MIN*MIN cannot overflow the product word
  function automatic logic [WIDTH-1:0] f_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic dbl);
    logic signed [PW-1:0] ea;
    logic signed [PW-1:0] eb;
    logic signed [PW-1:0] p;
    ea = $signed(f_sx(a));
    eb = $signed(f_sx(b));
    p  = ea * eb;
    return dbl ? f_sat(p >>> (FRACTIONAL - 1)) : f_sat(p >>> FRACTIONAL);
  endfunction

  logic                  r_v1, r_v2, r_v3;
  logic [WIDTH-1:0]      r_zr1, r_zi1, r_sqr1, r_sqi1, r_xy1, r_cr1, r_ci1;
  logic [ITER_WIDTH-1:0] r_it1, r_it2, r_it3;
  logic                  r_dn1, r_dn2, r_dn3;
  logic [ID_WIDTH-1:0]   r_id1, r_id2, r_id3;
  logic [WIDTH-1:0]      r_zr2, r_zi2, r_zr3, r_zi3, r_sz3;

  logic                  w_en;
  logic [WIDTH-1:0]      w_zr2, w_zi2, w_sz3;
  logic [ITER_WIDTH-1:0] w_it2;
  logic                  w_dn2, w_esc;

  assign w_en     = !r_v3 || out_ready;
  assign in_ready = w_en;

  always_comb begin
    w_zr2 = r_zr1;
    w_zi2 = r_zi1;
    w_it2 = r_it1;
    if (!r_dn1) begin
      w_zr2 = f_sat(f_sx(r_sqr1) - f_sx(r_sqi1) + f_sx(r_cr1));
      w_zi2 = f_sat(f_sx(r_xy1) + f_sx(r_ci1));
      w_it2 = (r_it1 >= MAX_I) ? MAX_I : r_it1 + ITER_WIDTH'(1);
    end
    w_dn2 = r_dn1 || (w_it2 == MAX_I);
  end

  // Both squares are non-negative, so the sum can only saturate upward
  always_comb begin
    w_sz3 = f_sat(f_sx(f_mul(r_zr2, r_zr2, 1'b0)) + f_sx(f_mul(r_zi2, r_zi2, 1'b0)));
    w_esc = $signed(w_sz3) > $signed(ESC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0;
      r_zr1 <= '0; r_zi1 <= '0; r_sqr1 <= '0; r_sqi1 <= '0; r_xy1 <= '0;
      r_cr1 <= '0; r_ci1 <= '0; r_it1 <= '0; r_dn1 <= 1'b0; r_id1 <= '0;
      r_zr2 <= '0; r_zi2 <= '0; r_it2 <= '0; r_dn2 <= 1'b0; r_id2 <= '0;
      r_zr3 <= '0; r_zi3 <= '0; r_sz3 <= '0; r_it3 <= '0; r_dn3 <= 1'b0; r_id3 <= '0;
    end else if (w_en) begin
      r_v1   <= in_valid;
      r_zr1  <= z_real_in;
      r_zi1  <= z_imag_in;
      r_sqr1 <= f_mul(z_real_in, z_real_in, 1'b0);
      r_sqi1 <= f_mul(z_imag_in, z_imag_in, 1'b0);
      r_xy1  <= f_mul(z_real_in, z_imag_in, 1'b1);
      r_cr1  <= c_real_in;
      r_ci1  <= c_imag_in;
      r_it1  <= iteration_in;
      r_dn1  <= done_in;
      r_id1  <= id_in;

      r_v2   <= r_v1;
      r_zr2  <= w_zr2;
      r_zi2  <= w_zi2;
      r_it2  <= w_it2;
      r_dn2  <= w_dn2;
      r_id2  <= r_id1;

      r_v3   <= r_v2;
      r_zr3  <= r_zr2;
      r_zi3  <= r_zi2;
      r_sz3  <= w_sz3;
      r_it3  <= r_it2;
      r_dn3  <= r_dn2 || w_esc;
      r_id3  <= r_id2;
    end
  end

  assign out_valid        = r_v3;
  assign z_real_out       = r_zr3;
  assign z_imag_out       = r_zi3;
  assign size_squared_out = r_sz3;
  assign iteration_out    = r_it3;
  assign done_out         = r_dn3;
  assign id_out           = r_id3;

endmodule

// File: tb/tb_z_calculator_pipe.sv
// tb/tb_z_calculator_pipe.sv - directed vectors plus scoreboard for z_calculator_pipe
module tb_z_calculator_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, done_in, done_out;
  logic [19:0] z_real_in, z_imag_in, c_real_in, c_imag_in;
  logic [19:0] z_real_out, z_imag_out, size_squared_out;
  logic [7:0]  iteration_in, iteration_out;
  logic [15:0] id_in, id_out;

  z_calculator_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .z_real_in(z_real_in), .z_imag_in(z_imag_in),
    .c_real_in(c_real_in), .c_imag_in(c_imag_in),
    .iteration_in(iteration_in), .done_in(done_in), .id_in(id_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .z_real_out(z_real_out), .z_imag_out(z_imag_out),
    .size_squared_out(size_squared_out), .iteration_out(iteration_out),
    .done_out(done_out), .id_out(id_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint zr;
    longint zi;
    longint sz;
    longint it;
    longint dn;
    longint id;
  } exp_t;

  exp_t   q[$];
  longint taken[$];
  int     n_vec = 0;
  int     n_err = 0;
  int     next_id = 100;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > 524287) return 524287;
    if (v < -524288) return -524288;
    return v;
  endfunction

  function automatic longint sq(input longint x);
    return sat((x * x) >>> 10);
  endfunction

  // Reference iteration in plain integer arithmetic (Q10.10, floor on shift)
  function automatic exp_t model(input longint zr, input longint zi, input longint cr, input longint ci,
                                 input longint it, input longint dn, input longint id);
    exp_t e;
    e.id = id;
    if (dn != 0) begin
      e.zr = zr; e.zi = zi; e.it = it; e.dn = 1;
      e.sz = sat(sq(zr) + sq(zi));
    end else begin
      e.zr = sat(sq(zr) - sq(zi) + cr);
      e.zi = sat(sat((2 * zr * zi) >>> 10) + ci);
      e.it = (it >= 255) ? 255 : it + 1;
      e.sz = sat(sq(e.zr) + sq(e.zi));
      e.dn = (e.sz > 4096 || e.it == 255) ? 1 : 0;
    end
    return e;
  endfunction

  logic        stall_prev = 1'b0;
  logic [19:0] h_zr, h_sz;
  logic [15:0] h_id;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 64'(out_valid), 1);
        chk("hold_z_real", 64'(z_real_out), 64'(h_zr));
        chk("hold_size", 64'(size_squared_out), 64'(h_sz));
        chk("hold_id", 64'(id_out), 64'(h_id));
      end
      if (out_valid && !out_ready) chk("stall_in_ready", 64'(in_ready), 0);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 0);
        end else begin
          chk("sb_z_real", 64'($signed(z_real_out)), q[0].zr);
          chk("sb_z_imag", 64'($signed(z_imag_out)), q[0].zi);
          chk("sb_size", 64'($signed(size_squared_out)), q[0].sz);
          chk("sb_iter", 64'(iteration_out), q[0].it);
          chk("sb_done", 64'(done_out), q[0].dn);
          chk("sb_id", 64'(id_out), q[0].id);
          if (out_ready) begin
            void'(q.pop_front());
            taken.push_back(64'(id_out));
          end
        end
      end
      if (in_valid && in_ready)
        q.push_back(model(64'($signed(z_real_in)), 64'($signed(z_imag_in)), 64'($signed(c_real_in)),
                          64'($signed(c_imag_in)), 64'(iteration_in), 64'(done_in), 64'(id_in)));
      stall_prev = out_valid && !out_ready;
      h_zr = z_real_out;
      h_sz = size_squared_out;
      h_id = id_out;
    end
  end

  task automatic send(input int zr, input int zi, input int cr, input int ci,
                      input int it, input bit dn, input int id);
    bit got;
    got = 1'b0;
    z_real_in = 20'(zr); z_imag_in = 20'(zi);
    c_real_in = 20'(cr); c_imag_in = 20'(ci);
    iteration_in = 8'(it); done_in = dn; id_in = 16'(id);
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("send_timeout", 64'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic vec(input string nm, input int zr, input int zi, input int cr, input int ci,
                     input int it, input bit dn,
                     input int ezr, input int ezi, input int esz, input int eit, input int edn);
    bit seen;
    seen = 1'b0;
    send(zr, zi, cr, ci, it, dn, next_id);
    next_id++;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({nm, ".out_timeout"}, 64'(out_valid), 1);
    chk({nm, ".z_real"}, 64'($signed(z_real_out)), 64'(ezr));
    chk({nm, ".z_imag"}, 64'($signed(z_imag_out)), 64'(ezi));
    chk({nm, ".size"}, 64'($signed(size_squared_out)), 64'(esz));
    chk({nm, ".iter"}, 64'(iteration_out), 64'(eit));
    chk({nm, ".done"}, 64'(done_out), 64'(edn));
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 40 && q.size() != 0; k++) @(negedge clk);
    chk(nm, 64'(q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; done_in = 1'b0;
    z_real_in = '0; z_imag_in = '0; c_real_in = '0; c_imag_in = '0;
    iteration_in = '0; id_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.out_valid", 64'(out_valid), 0);
    chk("rst.in_ready", 64'(in_ready), 1);
    chk("rst.z_real", 64'(z_real_out), 0);
    chk("rst.z_imag", 64'(z_imag_out), 0);
    chk("rst.size", 64'(size_squared_out), 0);
    chk("rst.iter", 64'(iteration_out), 0);
    chk("rst.done", 64'(done_out), 0);
    chk("rst.id", 64'(id_out), 0);

    //   name         zr      zi      cr    ci  it  dn   ezr      ezi   esz     eit  edn
    vec("t1",         1024,   512,    -512, 512, 1,  0,  256,     1536, 2368,   2,   0);
    vec("t2",         256,    1536,   -512, 512, 2,  0,  -2752,   1280, 8996,   3,   1);
    vec("t3_sat",     409600, 0,      0,    0,   0,  0,  524287,  0,    524287, 1,   1);
    vec("t4_max",     0,      0,      0,    0,   254, 0, 0,       0,    0,      255, 1);
    vec("t4_pass",    0,      0,      0,    0,   7,  1,  0,       0,    0,      7,   1);
    vec("pass_nz",    1024,   512,    -512, 512, 3,  1,  1024,    512,  1280,   3,   1);
    vec("iter_clamp", 0,      0,      0,    0,   255, 0, 0,       0,    0,      255, 1);
    vec("esc_eq",     0,      0,      2048, 0,   5,  0,  2048,    0,    4096,   6,   0);
    vec("esc_gt",     0,      0,      2049, 0,   5,  0,  2049,    0,    4100,   6,   1);
    vec("floor",      1,      -1,     0,    0,   0,  0,  0,       -1,   0,      1,   0);
    vec("neg_sat",    0,      409600, -512, 0,   0,  0,  -524288, 0,    524287, 1,   1);
    drain("vec.drain");

    @(posedge clk); #1;
    taken.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) send(300 * i, -200 * i, 100, -50, i, 1'b0, i);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("stall.drain");
    chk("stall.count", 64'(taken.size()), 6);
    for (int i = 0; i < 6 && i < taken.size(); i++) chk("stall.order", taken[i], 64'(i));

    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send(512 * i, 256, 64, 32, 10, 1'b0, 200 + i);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst6.out_valid", 64'(out_valid), 0);
    chk("rst6.z_real", 64'(z_real_out), 0);
    chk("rst6.size", 64'(size_squared_out), 0);
    chk("rst6.iter", 64'(iteration_out), 0);
    chk("rst6.done", 64'(done_out), 0);
    chk("rst6.id", 64'(id_out), 0);
    repeat (5) @(posedge clk);
    #1;
    send(1024, 512, -512, 512, 1, 1'b0, 77);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk("rst6.latency", 64'(lat), 3);
    chk("rst6.id_after", 64'(id_out), 77);
    drain("rst6.drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
